prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Parametrised program sequencer feeding config-cell opcodes to the control cell. It holds a runtime-writable instruction memory, and streams words 0..last_addr over a valid/ready handshake after a start pulse. It signals completion and can be aborted mid-run. It replaces the file-preloaded, free-running loader: programs are written through a host port, and the consumer can apply back-pressure.

## Interface
- CODE_BITS, 29: instruction word width.
- PC_BITS, 12: address width; memory depth is 2**PC_BITS words.
- LOOP_BITS, 8: repeat-counter width; used only with PROG_SEQ_LOOP_EN.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  host write strobe; ignored while busy=1.
- wr_addr  in  PC_BITS  host write address.
- wr_data  in  CODE_BITS  host write data.
- start  in  1  begin a run; accepted only in IDLE.
- abort  in  1  terminate the current run.
- last_addr  in  PC_BITS  address of the final word, inclusive; sampled on accepted start.
- loop_count  in  LOOP_BITS  extra passes; sampled on accepted start (PROG_SEQ_LOOP_EN only).
- code_out  out  CODE_BITS  current opcode.
- code_valid  out  1  code_out holds a valid opcode.
- code_ready  in  1  consumer accepts code_out this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final word is accepted.
- pc  out  PC_BITS  address of the next word to fetch.

## Operation
- Memory: 2**PC_BITS x CODE_BITS, written synchronously, read asynchronously at pc. The read result is registered into code_out. Memory contents are not reset.
- States:
  - IDLE: busy=0, code_valid=0.
  - RUN: busy=1.
- IDLE -> RUN on start (abort=0):
  - Latch last_addr.
  - Load code_out=mem[0] and set code_valid=1.
  - Set pc=1 (wraps to 0 if last_addr=0 and depth=1).
- RUN advance condition: code_valid && code_ready.
  - If the accepted word was not at last_addr: load code_out=mem[pc] and set pc=pc+1.
  - If it was at last_addr and no passes remain: clear code_valid, pulse done=1, go to IDLE, set pc=0.
- Holding: with code_valid=1 and code_ready=0, code_out and pc are held stable.
- abort in RUN (priority over advance):
  - Next cycle: code_valid=0, state IDLE, pc=0.
  - No done pulse.
- abort in IDLE: no effect. start together with abort in IDLE: ignored.
- start while in RUN: ignored.
- Host writes:
  - Performed only when busy=0.
  - A write in the same cycle as an accepted start is performed. code_out still reflects pre-write contents if wr_addr=0.
- last_addr = 2**PC_BITS-1: pc wraps to 0 after the last fetch; that wrap is not an error.
- rst: state IDLE, code_out=0, code_valid=0, busy=0, done=0, pc=0, loop counter=0.

## Timing
- Latency: start at edge N -> code_valid=1 with mem[0] after edge N.
- Throughput: one word per cycle while code_ready=1, with no bubbles, including across a loop wrap.
- done is asserted in the cycle after the final handshake; busy falls in that same cycle.
- An accepted start may follow done on the very next cycle.
- An asynchronous rst mid-run clears all outputs immediately.

## Configuration
- PROG_SEQ_LOOP_EN defined:
  - On start, the repeat counter = loop_count.
  - Accepting the word at last_addr with counter>0: load code_out=mem[0], set pc=1, decrement the counter, stay in RUN.
  - Total passes = loop_count+1.
- Not defined:
  - loop_count port is absent.
  - Exactly one pass per start.

## Test plan
- Write mem[0..3]=A0,A1,A2,A3; start with last_addr=3, code_ready=1 -> A0..A3 on four consecutive cycles, then done pulse, busy=0, pc=0.
- Same program with code_ready toggling 1,0,0,1,... -> each word held stable while ready=0; all four words delivered exactly once, in order.
- abort asserted while A1 is valid -> code_valid=0 next cycle, no done pulse, idle; a subsequent start replays from A0.
- wr_en to address 1 while busy -> mem[1] unchanged after the run (re-run yields A1); start pulse during RUN -> ignored.
- last_addr=0, depth test with PC_BITS=2, last_addr=3 -> single-word and full-depth-wrap runs complete with one done pulse each.
- PROG_SEQ_LOOP_EN, loop_count=2, last_addr=1 -> sequence A0,A1,A0,A1,A0,A1 back-to-back, then done; rst asserted mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: host-writable instruction memory streamed to the control cell over
// valid/ready after a start pulse. Define PROG_SEQ_LOOP_EN to enable repeated passes.
module prog_sequencer #(
  parameter int unsigned CODE_BITS = 29,
  parameter int unsigned PC_BITS   = 12,
  parameter int unsigned LOOP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [PC_BITS-1:0]   wr_addr,
  input  logic [CODE_BITS-1:0] wr_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PC_BITS-1:0]   last_addr,
`ifdef PROG_SEQ_LOOP_EN
  input  logic [LOOP_BITS-1:0] loop_count,
`endif
  output logic [CODE_BITS-1:0] code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 busy,
  output logic                 done,
  output logic [PC_BITS-1:0]   pc
);

  localparam int unsigned        Depth  = 2 ** PC_BITS;
  localparam logic [PC_BITS-1:0] PcZero = '0;
  localparam logic [PC_BITS-1:0] PcOne  = PC_BITS'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [CODE_BITS-1:0]   code_q, code_d;
  logic                   valid_q, valid_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [PC_BITS-1:0]     last_q, last_d;
  logic [LOOP_BITS-1:0]   loop_q, loop_d;
  logic                   done_q, done_d;

  logic [CODE_BITS-1:0]   mem_q [Depth];
  logic                   at_last;
  logic                   advance;

  assign busy       = (state_q == StRun);
  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign done       = done_q;
  assign pc         = pc_q;

  // pc always points one past the word on code_out, so the word is final when pc == last+1.
  assign at_last = (pc_q == (last_q + PcOne));
  assign advance = valid_q && code_ready;

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          last_d  = last_addr;
          code_d  = mem_q[PcZero];
          valid_d = 1'b1;
          pc_d    = PcOne;
`ifdef PROG_SEQ_LOOP_EN
          loop_d  = loop_count;
`else
          loop_d  = '0;
`endif
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          pc_d    = PcZero;
        end else if (advance) begin
          if (!at_last) begin
            code_d = mem_q[pc_q];
            pc_d   = pc_q + PcOne;
          end else if (loop_q != '0) begin
            // Restart the pass without a bubble.
            code_d = mem_q[PcZero];
            pc_d   = PcOne;
            loop_d = loop_q - LOOP_BITS'(1);
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            done_d  = 1'b1;
            pc_d    = PcZero;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      code_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      last_q  <= '0;
      loop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: run table plus scoreboard of expected words,
// with hand sequences for reset, idle corner cases and a small full-depth instance.
module tb_prog_sequencer;

  localparam int unsigned CB = 29;
  localparam int unsigned PB = 12;
  localparam int unsigned LB = 8;

  typedef struct {
    int          last;
    logic [3:0]  rdy;
    int          abort_at;
    bit          poke;
    bit          wr0;
    logic [28:0] wr0_data;
    int          loops;
  } vec_t;

  typedef struct {
    int          addr;
    logic [28:0] data;
  } exp_t;

  logic          clk, rst;
  logic          wr_en, start, abort, code_ready;
  logic [PB-1:0] wr_addr, last_addr;
  logic [CB-1:0] wr_data;
  logic [LB-1:0] loop_count;
  logic [CB-1:0] code_out;
  logic          code_valid, busy, done;
  logic [PB-1:0] pc;

  logic          s_wr_en, s_start, s_abort, s_ready;
  logic [1:0]    s_wr_addr, s_last;
  logic [CB-1:0] s_wr_data, s_code;
  logic [LB-1:0] s_loop;
  logic          s_valid, s_busy, s_done;
  logic [1:0]    s_pc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [28:0] model_mem [16];
  exp_t        sb [$];
  vec_t        tbl [$];

  prog_sequencer #(.CODE_BITS(CB), .PC_BITS(PB), .LOOP_BITS(LB)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .abort     (abort),
    .last_addr (last_addr),
`ifdef PROG_SEQ_LOOP_EN
    .loop_count(loop_count),
`endif
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  prog_sequencer #(.CODE_BITS(CB), .PC_BITS(2), .LOOP_BITS(LB)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (s_wr_en),
    .wr_addr   (s_wr_addr),
    .wr_data   (s_wr_data),
    .start     (s_start),
    .abort     (s_abort),
    .last_addr (s_last),
`ifdef PROG_SEQ_LOOP_EN
    .loop_count(s_loop),
`endif
    .code_out  (s_code),
    .code_valid(s_valid),
    .code_ready(s_ready),
    .busy      (s_busy),
    .done      (s_done),
    .pc        (s_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input int addr, input logic [28:0] data, input bit taken);
    wr_en   = 1'b1;
    wr_addr = PB'(addr);
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (taken) model_mem[addr] = data;
  endtask

  // Starts a run, pushes its expected words, then plays the consumer until completion.
  task automatic run_seq(input vec_t v);
    int            hs;
    int            cyc;
    int            passes;
    bit            fin;
    bit            aborted;
    logic [PB-1:0] epc;
    hs = 0; cyc = 0; fin = 0; aborted = 0;
`ifdef PROG_SEQ_LOOP_EN
    passes = v.loops + 1;
`else
    passes = 1;
`endif
    sb.delete();
    for (int p = 0; p < passes; p++)
      for (int a = 0; a <= v.last; a++) sb.push_back('{a, model_mem[a]});
    last_addr  = PB'(v.last);
    loop_count = LB'(v.loops);
    start      = 1'b1;
    if (v.wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = v.wr0_data;
    end
    @(posedge clk); #1;
    if (v.wr0) model_mem[0] = v.wr0_data;
    start = 1'b0; wr_en = 1'b0;
    while (!fin && cyc < 200) begin
      code_ready = v.rdy[cyc % 4];
      abort = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (v.abort_at >= 0 && hs == v.abort_at) begin
        abort = 1'b1; code_ready = 1'b0;
      end
      if (v.poke && cyc == 1) begin
        wr_en = 1'b1; wr_addr = PB'(1); wr_data = 29'h1ABCDE; start = 1'b1;
      end
      @(negedge clk);
      chk("run_valid", 64'(code_valid), 64'd1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      if (sb.size() > 0) begin
        epc = PB'(sb[0].addr + 1);
        chk("code_out", 64'(code_out), 64'(sb[0].data));
        chk("pc", 64'(pc), 64'(epc));
      end
      if (abort) begin
        aborted = 1; fin = 1;
      end else if (code_ready) begin
        void'(sb.pop_front());
        hs++;
        if (sb.size() == 0) fin = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0; code_ready = 1'b0; wr_en = 1'b0; start = 1'b0;
    if (!fin) chk("run_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("end_valid", 64'(code_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_pc", 64'(pc), 64'd0);
    chk("end_done", 64'(done), aborted ? 64'd0 : 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; start = 0; abort = 0; code_ready = 0;
    wr_addr = '0; wr_data = '0; last_addr = '0; loop_count = '0;
    s_wr_en = 0; s_start = 0; s_abort = 0; s_ready = 0;
    s_wr_addr = '0; s_wr_data = '0; s_last = '0; s_loop = '0;

    tbl.push_back('{3, 4'hF,    -1, 0, 0, 29'h0, 0});
    tbl.push_back('{3, 4'b1001, -1, 0, 0, 29'h0, 0});
    tbl.push_back('{3, 4'hF,     1, 0, 0, 29'h0, 0});
    tbl.push_back('{3, 4'hF,    -1, 1, 0, 29'h0, 0});
    tbl.push_back('{3, 4'b0110, -1, 0, 0, 29'h0, 0});
    tbl.push_back('{0, 4'hF,    -1, 0, 0, 29'h0, 0});
    tbl.push_back('{2, 4'hF,    -1, 0, 1, 29'h0E0E0E0, 0});
    tbl.push_back('{1, 4'b1101, -1, 0, 0, 29'h0, 0});
`ifdef PROG_SEQ_LOOP_EN
    tbl.push_back('{1, 4'hF,    -1, 0, 0, 29'h0, 2});
`endif

    #2;
    chk("rst_code", 64'(code_out), 64'd0);
    chk("rst_valid", 64'(code_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) host_write(i, 29'h0AA0000 | 29'(i), 1);

    // start together with abort in idle must be ignored
    start = 1'b1; abort = 1'b1; last_addr = PB'(3);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_valid", 64'(code_valid), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_seq(tbl[i]);

    // asynchronous reset in the middle of a run
    last_addr = PB'(3); start = 1'b1; code_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(code_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_code", 64'(code_out), 64'd0);
    chk("mid_rst_valid", 64'(code_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'd0);
    code_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_seq(tbl[0]);

    // full-depth wrap on a 4-word instance
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 2'(i); s_wr_data = 29'h0BB0000 | 29'(i);
      @(posedge clk); #1;
    end
    s_wr_en = 1'b0;
    s_last = 2'd3; s_start = 1'b1; s_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("small_valid", 64'(s_valid), 64'd1);
      chk("small_code", 64'(s_code), 64'(29'h0BB0000 | 29'(i)));
      chk("small_pc", 64'(s_pc), 64'((i + 1) % 4));
      chk("small_done", 64'(s_done), 64'd0);
      @(posedge clk); #1;
    end
    s_ready = 1'b0;
    @(negedge clk);
    chk("small_end_done", 64'(s_done), 64'd1);
    chk("small_end_busy", 64'(s_busy), 64'd0);
    chk("small_end_valid", 64'(s_valid), 64'd0);
    chk("small_end_pc", 64'(s_pc), 64'd0);
    @(negedge clk);
    chk("small_done_pulse", 64'(s_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
